// File: rtl/jacaranda_pkg.sv
// Shared widths, defaults and the buffered-entry type for the instruction fetch path.
package jacaranda_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 8;
  localparam int FIFO_DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at the top of the 8-bit space.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect request and the decode handshake.
interface fetch_unit_if;
  import jacaranda_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer: head register feeds the output, tail holds the younger entry.
module fetch_fifo
  import jacaranda_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  // Head keeps its old contents when the buffer empties, so out_instr/out_pc hold.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = din;
          end else begin
            tail_d = din;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == FULL) begin
            head_d = tail_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == FULL) begin
            head_d = tail_q;
            tail_d = din;
          end else begin
            head_d = din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns fetch_pc and the push/pop/redirect control
// around a two-entry prefetch buffer.
module fetch_unit
  import jacaranda_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = FIFO_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        fifo_count;
  fetch_entry_t      fifo_din;
  fetch_entry_t      fifo_dout;
  logic              buf_valid;
  logic              buf_full;
  logic              do_pop;
  logic              do_push;

  // out_valid comes straight from the registered occupancy, never from out_ready.
  assign buf_valid = (fifo_count != 2'd0);
  assign buf_full  = (fifo_count == 2'(DEPTH));

  // A redirect wins over everything: it flushes, and neither pushes nor pops.
  assign do_pop  = buf_valid && bus.out_ready && !bus.redirect_valid;
  assign do_push = !bus.redirect_valid && (!buf_full || do_pop);

  assign fifo_din.pc    = fetch_pc_q;
  assign fifo_din.instr = bus.imem_instr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (do_push) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .flush (bus.redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = buf_valid;
  assign bus.out_instr = fifo_dout.instr;
  assign bus.out_pc    = fifo_dout.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, is the PC loaded on reset.
REQ-002 Parameter DEPTH, default 2, is the prefetch buffer depth; only the value 2 is supported.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 imem_addr  out  8  fetch address to the instruction memory; that memory is a combinational read.
REQ-006 imem_instr  in  8  instruction byte at imem_addr, valid in the same cycle.
REQ-007 redirect_valid  in  1  one-cycle pulse: discard buffered instructions and resume fetch at redirect_pc.
REQ-008 redirect_pc  in  8  new fetch address, sampled only when redirect_valid=1.
REQ-009 out_valid  out  1  out_instr/out_pc hold a buffered instruction.
REQ-010 out_instr  out  8  oldest buffered instruction byte.
REQ-011 out_pc  out  8  address that out_instr was fetched from.
REQ-012 out_ready  in  1  the decode stage accepts the entry this cycle.

Function
REQ-013 fetch_pc SHALL be an internal 8-bit register; imem_addr SHALL equal fetch_pc combinationally.
REQ-014 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-015 Push of {fetch_pc, imem_instr} SHALL occur when redirect_valid=0 and either count<2 or a pop occurs in the same cycle.
REQ-016 A push SHALL advance fetch_pc by 1 modulo 256, so 8'hFF wraps to 8'h00.
REQ-017 When no push occurs, fetch_pc SHALL hold its value.
REQ-018 Simultaneous push and pop at count=2 SHALL leave count=2 and preserve FIFO order.
REQ-019 Simultaneous push and pop at count=1 SHALL leave count=1.
REQ-020 redirect_valid=1 SHALL have priority over push and pop.
REQ-021 On redirect: count<=0, fetch_pc<=redirect_pc, no push, no pop. out_ready is ignored in that cycle.
REQ-022 out_valid SHALL equal (count!=0), registered-state derived, with no combinational path from out_ready or redirect_valid.
REQ-023 out_instr and out_pc SHALL present the head entry. When count=0 they SHALL hold their last value and are don't-care for checking.
REQ-024 Latency: an instruction at address A fetched in cycle N SHALL appear at the head with out_valid=1 in cycle N+1 if the buffer was empty.
REQ-025 After a redirect in cycle N, out_valid SHALL be 0 in cycle N+1 and 1 in cycle N+2, with out_pc=redirect_pc.
REQ-026 With out_ready held 1, throughput SHALL be one instruction per cycle, with consecutive out_pc values.
REQ-027 With out_ready held 0, the buffer SHALL fill to 2 and then stop fetching; fetch_pc stays at head_pc+2.
REQ-028 count SHALL never exceed 2 or underflow.

Reset
REQ-029 While reset=1: fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=8'h00, out_pc=8'h00.
REQ-030 Reset assertion mid-operation SHALL take effect immediately (asynchronously), discarding buffered entries.
REQ-031 Fetching SHALL begin on the first rising edge after reset deasserts.

Structure
REQ-032 Package jacaranda_pkg SHALL hold ADDR_W=8, INSTR_W=8, and the default RESET_PC constant.
REQ-033 The two-entry buffer SHALL be a sub-module fetch_fifo: push, pop, flush, data in/out, count. fetch_unit holds only fetch_pc and the push/pop/redirect control.

Verification
REQ-034 Bench instruction memory model SHALL contain mem[0..3]=cf,da,0b,c2.
- Reset, then out_ready=1 -> out_pc/out_instr = 00/cf, 01/da, 02/0b on consecutive cycles starting cycle 2.
REQ-035 Backpressure: out_ready=0 for 5 cycles after reset -> count saturates at 2 and imem_addr stays 02. Then out_ready=1 -> sequence 00, 01, 02 with no gap or duplicate.
REQ-036 Redirect: redirect_valid=1, redirect_pc=8'h10 while the buffer is full and out_ready=1 -> no pop is counted. Next cycle out_valid=0; the following cycle out_pc=10.
REQ-037 Wrap: redirect to 8'hFE with out_ready=1 -> out_pc sequence FE, FF, 00, 01.
REQ-038 Async reset mid-stream at count=2, asserted between clock edges -> out_valid falls to 0 before the next edge. After release, out_pc restarts at 00.
REQ-039 Randomized out_ready with occasional redirects, checked against a scoreboard model -> every out_pc/out_instr pair matches the memory model, in order, with no loss after the last redirect.
